// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - BCD SS.CC countdown timer with run/pause, done pulse and alarm
// Counts down once per TICKS_PER_CS clk_time strobes; stops at 00.00.
module countdown_timer_bcd #(
   parameter int TICKS_PER_CS = 10000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_time,
   input  logic       load,
   input  logic [3:0] load_sec10,
   input  logic [3:0] load_sec1,
   input  logic [3:0] load_cs10,
   input  logic [3:0] load_cs1,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic [3:0] cs10,
   output logic [3:0] cs1,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {IDLE, PAUSE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICKS_PER_CS - 1);

   state_t           state_q, state_d;
   logic [3:0]       s10_q, s1_q, c10_q, c1_q;
   logic [3:0]       s10_d, s1_d, c10_d, c1_d;
   logic [3:0]       s10_dec, s1_dec, c10_dec, c1_dec;
   logic [3:0]       s10_ld, s1_ld, c10_ld, c1_ld;
   logic [CNT_W-1:0] pre_q, pre_d;
   logic             done_q, done_d;

   function automatic logic [3:0] clamp(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign s10_ld = clamp(load_sec10);
   assign s1_ld  = clamp(load_sec1);
   assign c10_ld = clamp(load_cs10);
   assign c1_ld  = clamp(load_cs1);

   // Borrow chain; only used in RUN where the value is known to be nonzero.
   always_comb begin
      s10_dec = s10_q;
      s1_dec  = s1_q;
      c10_dec = c10_q;
      c1_dec  = c1_q;
      if (c1_q != 4'd0) begin
         c1_dec = c1_q - 4'd1;
      end else begin
         c1_dec = 4'd9;
         if (c10_q != 4'd0) begin
            c10_dec = c10_q - 4'd1;
         end else begin
            c10_dec = 4'd9;
            if (s1_q != 4'd0) begin
               s1_dec = s1_q - 4'd1;
            end else begin
               s1_dec  = 4'd9;
               s10_dec = s10_q - 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      s10_d   = s10_q;
      s1_d    = s1_q;
      c10_d   = c10_q;
      c1_d    = c1_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      if (clear) begin
         {s10_d, s1_d, c10_d, c1_d} = 16'h0000;
         pre_d   = '0;
         state_d = IDLE;
      end else if (load) begin
         {s10_d, s1_d, c10_d, c1_d} = {s10_ld, s1_ld, c10_ld, c1_ld};
         pre_d   = '0;
         state_d = ({s10_ld, s1_ld, c10_ld, c1_ld} != 16'h0000) ? PAUSE : IDLE;
      end else if (start_stop && state_q == PAUSE) begin
         pre_d   = '0;
         state_d = RUN;
      end else if (start_stop && state_q == RUN) begin
         state_d = PAUSE;
      end else if (state_q == RUN && clk_time) begin
         if (pre_q == PRE_MAX) begin
            pre_d = '0;
            {s10_d, s1_d, c10_d, c1_d} = {s10_dec, s1_dec, c10_dec, c1_dec};
            if ({s10_q, s1_q, c10_q, c1_q} == 16'h0001) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end else begin
            pre_d = pre_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s10_q   <= 4'd0;
         s1_q    <= 4'd0;
         c10_q   <= 4'd0;
         c1_q    <= 4'd0;
         pre_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s10_q   <= s10_d;
         s1_q    <= s1_d;
         c10_q   <= c10_d;
         c1_q    <= c1_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
      end
   end

   assign sec10   = s10_q;
   assign sec1    = s1_q;
   assign cs10    = c10_q;
   assign cs1     = c1_q;
   assign running = (state_q == RUN);
   assign alarm   = (state_q == DONE);
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - self-checking bench for countdown_timer_bcd
// Reference keeps the time as a plain decimal SSCC integer and counts strobes.
module tb_countdown_timer_bcd;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clk_time = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_sec10 = 4'd0, load_sec1 = 4'd0, load_cs10 = 4'd0, load_cs1 = 4'd0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] sec10, sec1, cs10, cs1;
   logic       running, done, alarm;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: value as 0..9999, mode 0 idle / 1 paused / 2 counting / 3 expired
   int m_val  = 0;
   int m_mode = 0;
   int m_pre  = 0;
   bit m_done = 1'b0;

   countdown_timer_bcd #(.TICKS_PER_CS(T), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .clk_time(clk_time), .load(load),
      .load_sec10(load_sec10), .load_sec1(load_sec1), .load_cs10(load_cs10), .load_cs1(load_cs1),
      .start_stop(start_stop), .clear(clear),
      .sec10(sec10), .sec1(sec1), .cs10(cs10), .cs1(cs1),
      .running(running), .done(done), .alarm(alarm)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int lim9(input logic [3:0] d);
      return (int'(d) > 9) ? 9 : int'(d);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".digits"}, {16'h0, sec10, sec1, cs10, cs1}, {16'h0, to_bcd(m_val)});
      chk({tag, ".running"}, {31'h0, running}, {31'h0, m_mode == 2});
      chk({tag, ".alarm"}, {31'h0, alarm}, {31'h0, m_mode == 3});
      chk({tag, ".done"}, {31'h0, done}, {31'h0, m_done});
   endtask

   task automatic model_step(input bit ct, input bit ld, input bit ss, input bit cl,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      m_done = 1'b0;
      if (cl) begin
         m_val = 0; m_pre = 0; m_mode = 0;
      end else if (ld) begin
         m_val  = lim9(a) * 1000 + lim9(b) * 100 + lim9(c) * 10 + lim9(d);
         m_pre  = 0;
         m_mode = (m_val != 0) ? 1 : 0;
      end else if (ss && m_mode == 1) begin
         m_mode = 2; m_pre = 0;
      end else if (ss && m_mode == 2) begin
         m_mode = 1;
      end else if (ct && m_mode == 2) begin
         m_pre++;
         if (m_pre == T) begin
            m_pre = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin
               m_mode = 3; m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic tick(input string tag, input bit ct, input bit ld, input bit ss, input bit cl,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
      clk_time = ct; load = ld; start_stop = ss; clear = cl;
      load_sec10 = a; load_sec1 = b; load_cs10 = c; load_cs1 = d;
      model_step(ct, ld, ss, cl, a, b, c, d);
      @(posedge clk);
      #1;
      clk_time = 1'b0; load = 1'b0; start_stop = 1'b0; clear = 1'b0;
      chk_model(tag);
   endtask

   task automatic strobes(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_load(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
      tick(tag, 0, 1, 0, 0, a, b, c, d);
   endtask

   task automatic do_ss(input string tag);
      tick(tag, 0, 0, 1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [15:0] dig;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.digits", {16'h0, sec10, sec1, cs10, cs1}, 32'h0);
      chk("reset.flags", {29'h0, running, done, alarm}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_ss("idle_ss");
      chk("idle_ss.running", {31'h0, running}, 32'h0);

      do_load("ld0003", 0, 0, 0, 3);
      do_ss("run0003");
      strobes("cnt_a", T);
      dig = {sec10, sec1, cs10, cs1};
      chk("after4", {16'h0, dig}, 32'h0002);
      strobes("cnt_b", T);
      dig = {sec10, sec1, cs10, cs1};
      chk("after8", {16'h0, dig}, 32'h0001);
      strobes("cnt_c", T);
      dig = {sec10, sec1, cs10, cs1};
      chk("after12", {16'h0, dig}, 32'h0000);
      chk("expire.flags", {29'h0, running, done, alarm}, 32'h3);
      strobes("hold_done", 3);
      chk("done_hold.flags", {29'h0, running, done, alarm}, 32'h1);

      do_load("ld1000", 1, 0, 0, 0);
      do_ss("run1000");
      strobes("borrow", T);
      dig = {sec10, sec1, cs10, cs1};
      chk("borrow_0999", {16'h0, dig}, 32'h0999);
      do_load("ld9999", 9, 9, 9, 9);
      chk("ld_in_run.running", {31'h0, running}, 32'h0);
      do_ss("run9999");
      strobes("dec9999", T);
      dig = {sec10, sec1, cs10, cs1};
      chk("dec_9998", {16'h0, dig}, 32'h9998);
      do_load("clamp", 4'hA, 4'hF, 4'h3, 4'hC);
      dig = {sec10, sec1, cs10, cs1};
      chk("clamp_9939", {16'h0, dig}, 32'h9939);

      do_load("ld0050", 0, 0, 5, 0);
      do_ss("run0050");
      strobes("pre2", 2);
      do_ss("pause");
      strobes("paused", 10);
      do_ss("resume");
      strobes("resume3", 3);
      dig = {sec10, sec1, cs10, cs1};
      chk("resume_still_0050", {16'h0, dig}, 32'h0050);
      strobes("resume4", 1);
      dig = {sec10, sec1, cs10, cs1};
      chk("resume_0049", {16'h0, dig}, 32'h0049);

      tick("ld_ss", 0, 1, 1, 0, 1, 2, 3, 4);
      dig = {sec10, sec1, cs10, cs1};
      chk("ld_ss.digits", {16'h0, dig}, 32'h1234);
      chk("ld_ss.running", {31'h0, running}, 32'h0);
      do_ss("run1234");
      tick("cl_ld", 0, 1, 0, 1, 5, 5, 5, 5);
      dig = {sec10, sec1, cs10, cs1};
      chk("cl_ld.digits", {16'h0, dig}, 32'h0000);
      chk("cl_ld.flags", {29'h0, running, done, alarm}, 32'h0);

      do_load("ld0005", 0, 0, 0, 5);
      do_ss("run0005");
      strobes("pre_rst", 2);
      #2;
      reset_n = 1'b0;
      #1;
      m_val = 0; m_mode = 0; m_pre = 0; m_done = 1'b0;
      chk("async_rst.digits", {16'h0, sec10, sec1, cs10, cs1}, 32'h0);
      chk("async_rst.flags", {29'h0, running, done, alarm}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_load("ld0000", 0, 0, 0, 0);
      do_ss("ss0000");
      strobes("zero_idle", 2 * T);
      chk("zero_idle.flags", {29'h0, running, done, alarm}, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         bit ct, ld, ss, cl;
         logic [3:0] a, b, c, d;
         ct = ($urandom_range(0, 99) < 75);
         ld = ($urandom_range(0, 99) < 3);
         ss = ($urandom_range(0, 99) < 6);
         cl = ($urandom_range(0, 199) < 1);
         if ($urandom_range(0, 1) == 0) begin
            a = 4'd0; b = 4'd0; c = 4'($urandom_range(0, 2));
         end else begin
            a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
         end
         d = 4'($urandom_range(0, 15));
         tick("rand", ct, ld, ss, cl, a, b, c, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
